left_barrel_shifter: RTL and testbench

- 32-bit logical left barrel shifter for the SimpleALU datapath (SLL operation).
- Shifts `data` left by `shiftamt` (0-31) through five cascaded mux stages of 16, 8, 4, 2 and 1 bits; vacated LSBs are zero-filled.
- Provides a combinational result for the ALU result mux.
- Also provides a registered copy with a valid flag for pipelined consumers.

---
 rtl/left_barrel_shifter.sv | 42 ++++
 tb/tb_left_barrel_shifter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/left_barrel_shifter.sv
// 32-bit logical left barrel shifter (SLL): five cascaded 16/8/4/2/1 mux stages, zero fill.
// Latency: result is combinational, result_q/out_valid lag by one cycle; there is no backpressure.
module left_barrel_shifter #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data,
    input  logic [4:0]        shiftamt,
    input  logic              in_valid,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_q,
    output logic              out_valid
);

    logic [WIDTH-1:0] s4;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s0;

    // Coarsest stage first; each stage is a 2:1 mux per bit on one shiftamt bit.
    assign s4 = shiftamt[4] ? {data[15:0], 16'b0} : data;
    assign s3 = shiftamt[3] ? {s4[23:0],   8'b0}  : s4;
    assign s2 = shiftamt[2] ? {s3[27:0],   4'b0}  : s3;
    assign s1 = shiftamt[1] ? {s2[29:0],   2'b0}  : s2;
    assign s0 = shiftamt[0] ? {s1[30:0],   1'b0}  : s1;

    assign result = s0;

    // result_q tracks result every cycle; out_valid says whether that capture was qualified.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q  <= '0;
            out_valid <= 1'b0;
        end else begin
            result_q  <= result;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_left_barrel_shifter.sv
module tb_left_barrel_shifter;

    logic        clock;
    logic        reset;
    logic [31:0] data;
    logic [4:0]  shiftamt;
    logic        in_valid;
    logic [31:0] result;
    logic [31:0] result_q;
    logic        out_valid;

    typedef struct {
        logic [31:0] r;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    left_barrel_shifter #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .shiftamt  (shiftamt),
        .in_valid  (in_valid),
        .result    (result),
        .result_q  (result_q),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_sll(input logic [31:0] d, input logic [4:0] sa);
        return d << sa;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational result, queue the
    // registered expectation, then retire it one edge later.
    task automatic step(input logic [31:0] d, input logic [4:0] sa, input logic v,
                        input logic [31:0] exp, input string tag);
        exp_t e;
        data = d; shiftamt = sa; in_valid = v;
        #1;
        chk({tag, "_comb"}, result, exp);
        sb.push_back('{r: exp, v: v});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, "_q"}, result_q, e.r);
        chk({tag, "_vld"}, {31'b0, out_valid}, {31'b0, e.v});
    endtask

    initial begin
        logic [31:0] rd;
        reset = 1'b1; data = 32'h0000FFFF; shiftamt = 5'd4; in_valid = 1'b1;
        #1;
        chk("rst_result_q", result_q, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_comb_unaffected", result, 32'h000FFFF0);
        @(posedge clock); #1;
        chk("rst_hold_q", result_q, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        step(32'h0000FFFF, 5'd16, 1'b1, 32'hFFFF0000, "half16");
        step(32'h0000FFFF, 5'd17, 1'b1, 32'hFFFE0000, "half17");
        step(32'h80000001, 5'd0,  1'b1, 32'h80000001, "sa0");
        step(32'h80000001, 5'd1,  0,    32'h00000002, "sa1_msb_drop");
        step(32'h80000001, 5'd31, 1'b1, 32'h80000000, "sa31");
        step(32'h00000001, 5'd1,  1'b1, 32'h00000002, "stage0");
        step(32'h00000001, 5'd2,  1'b1, 32'h00000004, "stage1");
        step(32'h00000001, 5'd4,  1'b0, 32'h00000010, "stage2");
        step(32'h00000001, 5'd8,  1'b1, 32'h00000100, "stage3");
        step(32'h00000001, 5'd16, 1'b1, 32'h00010000, "stage4");

        for (int k = 0; k < 4; k++) begin
            rd = $urandom();
            for (int s = 0; s < 32; s++)
                step(rd, s[4:0], s[0], ref_sll(rd, s[4:0]), "sweep");
        end

        // Asynchronous reset between edges while result_q is nonzero, with a new value in flight.
        step(32'h0000FFFF, 5'd16, 1'b1, 32'hFFFF0000, "pre_rst");
        data = 32'h12345678; shiftamt = 5'd3; in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_q", result_q, 32'h0);
        chk("async_rst_vld", {31'b0, out_valid}, 32'h0);
        chk("rst_comb_live", result, 32'h91A2B3C0);
        @(posedge clock); #1;
        chk("inflight_discard_q", result_q, 32'h0);
        chk("inflight_discard_vld", {31'b0, out_valid}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step(32'h0000FFFF, 5'd8, 1'b0, 32'h00FFFF00, "post_rst_invalid");
        step(32'hA5A5A5A5, 5'd12, 1'b1, 32'h5A5A5000, "post_rst_valid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
